alu: RTL and testbench

- Multi-cycle 8-bit sequential ALU with byte-serial operand input (inbus) and byte-serial result output (outbus).
- Supports unsigned add, subtract, shift-add multiply (8x8->16) and SRT radix-2 divide (16/8 -> 8-bit quotient and 8-bit remainder).
- A one-hot control FSM sequences the A/Q/M/Q' datapath registers. BEGIN starts an operation; END signals completion.
- Internal register and state values are exported on debug ports for bench visibility.

---
 rtl/alu.sv | 247 ++++++++++++++++++++++++
 tb/tb_alu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu : multi-cycle 8-bit sequential ALU
//
// Operands arrive byte-serially on inbus, results leave byte-serially on
// outbus. Supports unsigned add, subtract, shift-add multiply (8x8->16) and
// SRT radix-2 divide (16/8 -> 8-bit quotient, 8-bit remainder). A one-hot
// FSM sequences the A/Q/M/Q' datapath registers.
//
// Ports:
//   clk               in   1   system clock, rising edge
//   reset             in   1   synchronous, active-low
//   BEGIN             in   1   start strobe, sampled only in IDLE
//   op_code           in   2   00 add, 01 sub, 10 mul, 11 div
//   inbus             in   8   operand byte stream
//   outbus            out  8   registered result byte stream
//   END               out  1   one-cycle completion pulse
//   act_state_debug   out 17   current one-hot state
//   next_state_debug  out 17   combinational next state
//   A/Q/M/Qprim_reg_debug out 9  datapath registers
//   SRT2counter_debug out  3   iteration / normalisation counter
// ---------------------------------------------------------------------------
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic        BEGIN,
    input  logic [1:0]  op_code,
    input  logic [7:0]  inbus,
    output logic [7:0]  outbus,
    output logic        END,
    output logic [16:0] act_state_debug,
    output logic [16:0] next_state_debug,
    output logic [8:0]  A_reg_debug,
    output logic [8:0]  Q_reg_debug,
    output logic [8:0]  M_reg_debug,
    output logic [8:0]  Qprim_reg_debug,
    output logic [2:0]  SRT2counter_debug
);

    typedef enum logic [16:0] {
        IDLE        = 17'h00001,
        LD_A        = 17'h00002,
        LD_Q        = 17'h00004,
        LD_M        = 17'h00008,
        ADDSUB      = 17'h00010,
        MUL_INIT    = 17'h00020,
        MUL_ADD     = 17'h00040,
        MUL_SHIFT   = 17'h00080,
        DIV_CHECK   = 17'h00100,
        DIV_NORM    = 17'h00200,
        DIV_STEP    = 17'h00400,
        DIV_ADDSUB  = 17'h00800,
        DIV_CORRECT = 17'h01000,
        DIV_DENORM  = 17'h02000,
        OUT_1       = 17'h04000,
        OUT_2       = 17'h08000,
        DONE        = 17'h10000
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    state_t      state;
    state_t      next_state;
    op_t         op_reg;
    logic [8:0]  a_reg;
    logic [8:0]  q_reg;
    logic [8:0]  m_reg;
    logic [8:0]  qp_reg;
    logic [2:0]  counter;
    logic [2:0]  norm_shift;
    logic        a_ext;

    logic [7:0]  addsub_result;
    logic        div_overflow;
    logic [9:0]  srt_rem;
    logic [9:0]  srt_minus_m;
    logic [9:0]  srt_plus_m;
    logic        digit_pos;
    logic        digit_neg;

    // After the SRT left shift the partial remainder needs one bit more than
    // the 9-bit A register holds; a_ext carries that sign bit from DIV_STEP
    // into DIV_ADDSUB. Digit selection compares against +/-128: bits [9:7]
    // all equal means the remainder is in [-128,128) and the digit is 0.
    always_comb begin
        addsub_result = (op_reg == OP_SUB) ? (a_reg[7:0] - m_reg[7:0])
                                           : (a_reg[7:0] + m_reg[7:0]);
        div_overflow  = (m_reg[7:0] == 8'd0) || (a_reg[7:0] >= m_reg[7:0]);
        srt_rem       = {a_ext, a_reg};
        srt_minus_m   = srt_rem - {2'b00, m_reg[7:0]};
        srt_plus_m    = srt_rem + {2'b00, m_reg[7:0]};
        digit_pos     = !srt_rem[9] && (srt_rem[8:7] != 2'b00);
        digit_neg     =  srt_rem[9] && (srt_rem[8:7] != 2'b11);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        END        = 1'b0;
        case (state)
            IDLE:        if (BEGIN) next_state = LD_A;
            LD_A:        next_state = (op_reg == OP_DIV) ? LD_Q : LD_M;
            LD_Q:        next_state = LD_M;
            LD_M: begin
                case (op_reg)
                    OP_MUL:  next_state = MUL_INIT;
                    OP_DIV:  next_state = DIV_CHECK;
                    default: next_state = ADDSUB;
                endcase
            end
            ADDSUB:      next_state = OUT_1;
            MUL_INIT:    next_state = MUL_ADD;
            MUL_ADD:     next_state = MUL_SHIFT;
            MUL_SHIFT:   next_state = (counter == 3'd7) ? OUT_1 : MUL_ADD;
            DIV_CHECK:   next_state = div_overflow ? OUT_1 : DIV_NORM;
            DIV_NORM:    next_state = m_reg[7] ? DIV_STEP : DIV_NORM;
            DIV_STEP:    next_state = DIV_ADDSUB;
            DIV_ADDSUB:  next_state = (counter == 3'd7) ? DIV_CORRECT : DIV_STEP;
            DIV_CORRECT: next_state = DIV_DENORM;
            DIV_DENORM:  next_state = OUT_1;
            OUT_1:       next_state = (op_reg == OP_MUL || op_reg == OP_DIV) ? OUT_2 : DONE;
            OUT_2:       next_state = DONE;
            DONE: begin
                END        = 1'b1;
                next_state = IDLE;
            end
            default:     next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_reg     <= OP_ADD;
            a_reg      <= 9'd0;
            q_reg      <= 9'd0;
            m_reg      <= 9'd0;
            qp_reg     <= 9'd0;
            counter    <= 3'd0;
            norm_shift <= 3'd0;
            a_ext      <= 1'b0;
            outbus     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (BEGIN) begin
                        op_reg <= op_t'(op_code);
                        a_reg  <= {1'b0, inbus};
                    end
                end
                LD_A: begin
                    if (op_reg == OP_DIV) begin
                        q_reg <= {1'b0, inbus};
                    end else begin
                        m_reg <= {1'b0, inbus};
                    end
                end
                LD_Q: m_reg <= {1'b0, inbus};
                ADDSUB: a_reg <= {1'b0, addsub_result};
                // The first operand (in A) becomes the multiplier in Q;
                // A becomes the running upper half of the product.
                MUL_INIT: begin
                    q_reg   <= {1'b0, a_reg[7:0]};
                    a_reg   <= 9'd0;
                    counter <= 3'd0;
                end
                MUL_ADD: begin
                    if (q_reg[0]) a_reg <= a_reg + m_reg;
                end
                MUL_SHIFT: begin
                    a_reg   <= {1'b0, a_reg[8:1]};
                    q_reg   <= {1'b0, a_reg[0], q_reg[7:1]};
                    counter <= counter + 3'd1;
                end
                DIV_CHECK: begin
                    if (div_overflow) begin
                        a_reg <= 9'h0FF;
                        q_reg <= 9'h0FF;
                    end
                    qp_reg  <= 9'd0;
                    counter <= 3'd0;
                end
                // Shifting dividend and divisor by the same amount leaves the
                // quotient unchanged and scales the remainder, undone later.
                DIV_NORM: begin
                    if (!m_reg[7]) begin
                        m_reg   <= {1'b0, m_reg[6:0], 1'b0};
                        a_reg   <= {1'b0, a_reg[6:0], q_reg[7]};
                        q_reg   <= {1'b0, q_reg[6:0], 1'b0};
                        counter <= counter + 3'd1;
                    end else begin
                        norm_shift <= counter;
                        counter    <= 3'd0;
                    end
                end
                DIV_STEP: begin
                    {a_ext, a_reg} <= {a_reg, q_reg[7]};
                    q_reg          <= {1'b0, q_reg[6:0], 1'b0};
                    qp_reg         <= {1'b0, qp_reg[6:0], 1'b0};
                end
                DIV_ADDSUB: begin
                    if (digit_pos) begin
                        a_reg    <= srt_minus_m[8:0];
                        q_reg[0] <= 1'b1;
                    end else if (digit_neg) begin
                        a_reg     <= srt_plus_m[8:0];
                        qp_reg[0] <= 1'b1;
                    end
                    counter <= counter + 3'd1;
                end
                // Q - Q' turns the signed-digit quotient into binary; a
                // negative final remainder needs one restoring step.
                DIV_CORRECT: begin
                    if (a_reg[8]) begin
                        a_reg <= a_reg + m_reg;
                        q_reg <= {1'b0, q_reg[7:0] - qp_reg[7:0] - 8'd1};
                    end else begin
                        q_reg <= {1'b0, q_reg[7:0] - qp_reg[7:0]};
                    end
                end
                DIV_DENORM: a_reg <= a_reg >> norm_shift;
                OUT_1: outbus <= (op_reg == OP_DIV) ? q_reg[7:0] : a_reg[7:0];
                OUT_2: outbus <= (op_reg == OP_MUL) ? q_reg[7:0] : a_reg[7:0];
                default: ;
            endcase
        end
    end

    assign act_state_debug   = state;
    assign next_state_debug  = next_state;
    assign A_reg_debug       = a_reg;
    assign Q_reg_debug       = q_reg;
    assign M_reg_debug       = m_reg;
    assign Qprim_reg_debug   = qp_reg;
    assign SRT2counter_debug = counter;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu : self-checking bench for the sequential ALU
//
// Table of directed vectors with hand-computed results, plus hand-written
// sequences for BEGIN/op_code changes mid-operation and reset mid-multiply.
// ---------------------------------------------------------------------------
module tb_alu;

    typedef struct {
        logic [1:0] op;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] exp1;
        logic [7:0] exp2;
        logic       two;
        string      name;
    } vec_t;

    localparam int NUM_VECS = 14;

    logic        clk;
    logic        reset;
    logic        begin_sig;
    logic [1:0]  op_code;
    logic [7:0]  inbus;
    logic [7:0]  outbus;
    logic        end_sig;
    logic [16:0] act_state;
    logic [16:0] next_state;
    logic [8:0]  a_dbg;
    logic [8:0]  q_dbg;
    logic [8:0]  m_dbg;
    logic [8:0]  qp_dbg;
    logic [2:0]  cnt_dbg;

    int errors = 0;
    int checks = 0;

    vec_t vecs [NUM_VECS];
    vec_t hand_vec;

    alu dut (
        .clk               (clk),
        .reset             (reset),
        .BEGIN             (begin_sig),
        .op_code           (op_code),
        .inbus             (inbus),
        .outbus            (outbus),
        .END               (end_sig),
        .act_state_debug   (act_state),
        .next_state_debug  (next_state),
        .A_reg_debug       (a_dbg),
        .Q_reg_debug       (q_dbg),
        .M_reg_debug       (m_dbg),
        .Qprim_reg_debug   (qp_dbg),
        .SRT2counter_debug (cnt_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        begin_sig = 1'b1;
        op_code   = v.op;
        inbus     = v.b0;
        @(negedge clk);
        begin_sig = 1'b0;
        inbus     = v.b1;
        if (v.op == 2'b11) begin
            @(negedge clk);
            inbus = v.b2;
        end
    endtask

    task automatic wait_result(input vec_t v);
        logic [7:0] first_byte;
        logic [7:0] last_byte;
        logic       saw_out2;
        logic       saw_end;
        first_byte = 8'd0;
        last_byte  = 8'd0;
        saw_out2   = 1'b0;
        saw_end    = 1'b0;
        for (int cyc = 0; cyc < 80 && !saw_end; cyc++) begin
            @(negedge clk);
            if (act_state == 17'h08000) begin
                saw_out2   = 1'b1;
                first_byte = outbus;
            end
            if (end_sig) begin
                saw_end   = 1'b1;
                last_byte = outbus;
            end
        end
        checkOutput({v.name, " END seen"}, {31'd0, saw_end}, 32'd1);
        if (v.two) begin
            checkOutput({v.name, " byte1"}, {24'd0, first_byte}, {24'd0, v.exp1});
            checkOutput({v.name, " byte2"}, {24'd0, last_byte}, {24'd0, v.exp2});
        end else begin
            checkOutput({v.name, " skips OUT_2"}, {31'd0, saw_out2}, 32'd0);
            checkOutput({v.name, " result"}, {24'd0, last_byte}, {24'd0, v.exp1});
        end
        @(negedge clk);
        checkOutput({v.name, " END one cycle"}, {31'd0, end_sig}, 32'd0);
        checkOutput({v.name, " back to IDLE"}, {15'd0, act_state}, 32'h1);
        checkOutput({v.name, " outbus holds"}, {24'd0, outbus},
                    {24'd0, (v.two ? v.exp2 : v.exp1)});
    endtask

    initial begin
        logic found;
        int   shifts_seen;

        reset     = 1'b0;
        begin_sig = 1'b1;
        op_code   = 2'b10;
        inbus     = 8'h5A;

        vecs[0]  = '{2'b00, 8'd56,  8'd89,  8'h00, 8'h91, 8'h00, 1'b0, "add 56+89"};
        vecs[1]  = '{2'b01, 8'd56,  8'd89,  8'h00, 8'hDF, 8'h00, 1'b0, "sub 56-89"};
        vecs[2]  = '{2'b10, 8'd56,  8'd89,  8'h00, 8'h13, 8'h78, 1'b1, "mul 56*89"};
        vecs[3]  = '{2'b11, 8'h12,  8'h7B,  8'h59, 8'h35, 8'h0E, 1'b1, "div 4731/89"};
        vecs[4]  = '{2'b11, 8'h12,  8'h7B,  8'h00, 8'hFF, 8'hFF, 1'b1, "div by zero"};
        vecs[5]  = '{2'b11, 8'h80,  8'h00,  8'h10, 8'hFF, 8'hFF, 1'b1, "div overflow 80/10"};
        vecs[6]  = '{2'b11, 8'h10,  8'h00,  8'h10, 8'hFF, 8'hFF, 1'b1, "div overflow A==M"};
        vecs[7]  = '{2'b00, 8'd200, 8'd100, 8'h00, 8'h2C, 8'h00, 1'b0, "add wrap"};
        vecs[8]  = '{2'b01, 8'd100, 8'd100, 8'h00, 8'h00, 8'h00, 1'b0, "sub zero"};
        vecs[9]  = '{2'b10, 8'hFF,  8'hFF,  8'h00, 8'hFE, 8'h01, 1'b1, "mul FF*FF"};
        vecs[10] = '{2'b10, 8'h00,  8'd77,  8'h00, 8'h00, 8'h00, 1'b1, "mul 0*77"};
        vecs[11] = '{2'b11, 8'h00,  8'hFF,  8'h01, 8'hFF, 8'h00, 1'b1, "div 255/1"};
        vecs[12] = '{2'b11, 8'h00,  8'h07,  8'h03, 8'h02, 8'h01, 1'b1, "div 7/3"};
        vecs[13] = '{2'b11, 8'hFE,  8'hFF,  8'hFF, 8'hFF, 8'hFE, 1'b1, "div FEFF/FF"};

        // Reset held over several edges, with BEGIN asserted to prove priority
        repeat (3) @(negedge clk);
        checkOutput("reset state", {15'd0, act_state}, 32'h1);
        checkOutput("reset A", {23'd0, a_dbg}, 32'd0);
        checkOutput("reset Q", {23'd0, q_dbg}, 32'd0);
        checkOutput("reset M", {23'd0, m_dbg}, 32'd0);
        checkOutput("reset Qprim", {23'd0, qp_dbg}, 32'd0);
        checkOutput("reset counter", {29'd0, cnt_dbg}, 32'd0);
        checkOutput("reset outbus", {24'd0, outbus}, 32'd0);
        checkOutput("reset END", {31'd0, end_sig}, 32'd0);
        begin_sig = 1'b0;
        reset     = 1'b1;
        #1;
        checkOutput("idle next state", {15'd0, next_state}, 32'h1);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            wait_result(vecs[i]);
        end

        // BEGIN and op_code toggled while an add is in flight
        $display("[TB] BEGIN/op_code changes during an add");
        @(negedge clk);
        begin_sig = 1'b1;
        op_code   = 2'b00;
        inbus     = 8'd10;
        #1;
        checkOutput("IDLE next with BEGIN", {15'd0, next_state}, 32'h2);
        @(negedge clk);
        op_code = 2'b10;
        inbus   = 8'd20;
        @(negedge clk);
        inbus   = 8'hAA;
        @(negedge clk);
        begin_sig = 1'b0;
        hand_vec = '{2'b00, 8'd10, 8'd20, 8'h00, 8'h1E, 8'h00, 1'b0, "add with mid-op BEGIN"};
        wait_result(hand_vec);

        // Reset in the middle of a multiply, on the third MUL_SHIFT
        $display("[TB] reset during multiply");
        hand_vec = '{2'b10, 8'd56, 8'd89, 8'h00, 8'h13, 8'h78, 1'b1, "mul before reset"};
        applyStimulus(hand_vec);
        found       = 1'b0;
        shifts_seen = 0;
        for (int cyc = 0; cyc < 60 && !found; cyc++) begin
            @(negedge clk);
            if (act_state == 17'h00080) begin
                shifts_seen++;
                if (shifts_seen == 3) found = 1'b1;
            end
        end
        checkOutput("reached MUL_SHIFT", {31'd0, found}, 32'd1);
        reset     = 1'b0;
        begin_sig = 1'b1;
        @(negedge clk);
        checkOutput("mid reset state", {15'd0, act_state}, 32'h1);
        checkOutput("mid reset A", {23'd0, a_dbg}, 32'd0);
        checkOutput("mid reset Q", {23'd0, q_dbg}, 32'd0);
        checkOutput("mid reset M", {23'd0, m_dbg}, 32'd0);
        checkOutput("mid reset Qprim", {23'd0, qp_dbg}, 32'd0);
        checkOutput("mid reset counter", {29'd0, cnt_dbg}, 32'd0);
        checkOutput("mid reset outbus", {24'd0, outbus}, 32'd0);
        checkOutput("mid reset END", {31'd0, end_sig}, 32'd0);
        reset     = 1'b1;
        begin_sig = 1'b0;

        hand_vec = '{2'b11, 8'h12, 8'h7B, 8'h59, 8'h35, 8'h0E, 1'b1, "div after reset"};
        applyStimulus(hand_vec);
        wait_result(hand_vec);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
